// File: rtl/bip_pkg.sv
// Shared definitions for the multi-cycle BIP accumulator core:
// opcodes, FSM state encoding, ALU operation select and default widths.
package bip_pkg;

    localparam int NB_OPCODE_D   = 5;
    localparam int NB_OPERANDO_D = 11;
    localparam int NB_ADDR_D     = 11;
    localparam int NB_DATA_D     = 16;
    localparam int NB_CNT_D      = 32;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_ANDI = 5'b01001;
    localparam logic [4:0] OP_JMP  = 5'b01010;
    localparam logic [4:0] OP_BEQ  = 5'b01011;
    localparam logic [4:0] OP_BNE  = 5'b01100;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ALU_HOLD,
        ALU_PASS,
        ALU_ADD,
        ALU_SUB,
        ALU_AND
    } alu_op_e;

endpackage

// File: rtl/bip_alu.sv
// Accumulator ALU: combinational next-ACC value and ACC zero test.
// Ports: acc, opnd (memory data or immediate), op -> result, zero.
module bip_alu
    import bip_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_D
) (
    input  logic [NB_DATA-1:0] acc,
    input  logic [NB_DATA-1:0] opnd,
    input  alu_op_e            op,
    output logic [NB_DATA-1:0] result,
    output logic               zero
);

    always_comb begin
        result = acc;
        unique case (op)
            ALU_HOLD: result = acc;
            ALU_PASS: result = opnd;
            ALU_ADD:  result = acc + opnd;
            ALU_SUB:  result = acc - opnd;
            ALU_AND:  result = acc & opnd;
            default:  result = acc;
        endcase
    end

    assign zero = (acc == '0);

endmodule

// File: rtl/bip_cpu_mc.sv
// Multi-cycle BIP accumulator core with branches, data-memory wait states,
// halt and cycle counter. Ports: program memory (o_addr_pm, i_opcode_pm,
// i_operando_pm), data memory (o_addr_dm, o_rd_en, o_wr_en, o_data,
// i_data, i_dm_ready), debug (o_acc, o_halt, o_clk_count).
module bip_cpu_mc
    import bip_pkg::*;
#(
    parameter int NB_OPCODE   = NB_OPCODE_D,
    parameter int NB_OPERANDO = NB_OPERANDO_D,
    parameter int NB_ADDR     = NB_ADDR_D,
    parameter int NB_DATA     = NB_DATA_D,
    parameter int NB_CNT      = NB_CNT_D
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NB_OPCODE-1:0]   i_opcode_pm,
    input  logic [NB_OPERANDO-1:0] i_operando_pm,
    output logic [NB_ADDR-1:0]     o_addr_pm,
    output logic [NB_OPERANDO-1:0] o_addr_dm,
    output logic                   o_rd_en,
    output logic                   o_wr_en,
    output logic [NB_DATA-1:0]     o_data,
    input  logic [NB_DATA-1:0]     i_data,
    input  logic                   i_dm_ready,
    output logic [NB_DATA-1:0]     o_acc,
    output logic                   o_halt,
    output logic [NB_CNT-1:0]      o_clk_count
);

    state_e                 state;
    logic [NB_ADDR-1:0]     pc;
    logic [NB_DATA-1:0]     acc;
    logic [NB_OPCODE-1:0]   ir_op;
    logic [NB_OPERANDO-1:0] ir_opnd;
    logic [NB_CNT-1:0]      cnt;
    logic                   halt;

    logic [4:0]         opc;
    logic               is_hlt;
    logic               is_mem;
    logic               is_sto;
    logic               jump;
    logic               zero;
    logic               mem_act;
    alu_op_e            alu_op;
    logic [NB_DATA-1:0] imm;
    logic [NB_DATA-1:0] alu_in;
    logic [NB_DATA-1:0] alu_res;
    logic [NB_ADDR-1:0] pc_inc;
    logic [NB_ADDR-1:0] target;

    assign opc    = 5'(ir_op);
    assign imm    = NB_DATA'($signed(ir_opnd));
    assign target = NB_ADDR'(ir_opnd);
    assign pc_inc = pc + NB_ADDR'(1);
    assign alu_in = is_mem ? i_data : imm;

    always_comb begin
        is_hlt = 1'b0;
        is_mem = 1'b0;
        is_sto = 1'b0;
        jump   = 1'b0;
        alu_op = ALU_HOLD;
        case (opc)
            OP_HLT:  is_hlt = 1'b1;
            OP_STO:  begin is_mem = 1'b1; is_sto = 1'b1; end
            OP_LD:   begin is_mem = 1'b1; alu_op = ALU_PASS; end
            OP_LDI:  alu_op = ALU_PASS;
            OP_ADD:  begin is_mem = 1'b1; alu_op = ALU_ADD; end
            OP_ADDI: alu_op = ALU_ADD;
            OP_SUB:  begin is_mem = 1'b1; alu_op = ALU_SUB; end
            OP_SUBI: alu_op = ALU_SUB;
            OP_AND:  begin is_mem = 1'b1; alu_op = ALU_AND; end
            OP_ANDI: alu_op = ALU_AND;
            OP_JMP:  jump = 1'b1;
            OP_BEQ:  jump = zero;
            OP_BNE:  jump = !zero;
            default: ;
        endcase
    end

    bip_alu #(.NB_DATA(NB_DATA)) u_alu (
        .acc    (acc),
        .opnd   (alu_in),
        .op     (alu_op),
        .result (alu_res),
        .zero   (zero)
    );

    // Requests decode from state so reset drops them asynchronously.
    assign mem_act = (state == ST_EXEC || state == ST_MEM) && is_mem;
    assign o_rd_en = mem_act && !is_sto;
    assign o_wr_en = mem_act && is_sto;

    assign o_addr_pm   = pc;
    assign o_addr_dm   = ir_opnd;
    assign o_data      = acc;
    assign o_acc       = acc;
    assign o_halt      = halt;
    assign o_clk_count = cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_FETCH;
            pc      <= '0;
            acc     <= '0;
            ir_op   <= '0;
            ir_opnd <= '0;
            cnt     <= '0;
            halt    <= 1'b0;
        end else begin
            if (state != ST_HALT && cnt != '1)
                cnt <= cnt + NB_CNT'(1);
            unique case (state)
                ST_FETCH: begin
                    ir_op   <= i_opcode_pm;
                    ir_opnd <= i_operando_pm;
                    state   <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (is_hlt) begin
                        state <= ST_HALT;
                        halt  <= 1'b1;
                    end else if (is_mem) begin
                        if (i_dm_ready) begin
                            acc   <= alu_res;
                            pc    <= pc_inc;
                            state <= ST_FETCH;
                        end else begin
                            state <= ST_MEM;
                        end
                    end else begin
                        acc   <= alu_res;
                        pc    <= jump ? target : pc_inc;
                        state <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (i_dm_ready) begin
                        acc   <= alu_res;
                        pc    <= pc_inc;
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: ;
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_bip_cpu_mc.sv
// Self-checking bench for bip_cpu_mc: instruction-level reference model
// with per-cycle compare, directed programs and random programs.
module tb_bip_cpu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  i_opcode_pm;
    logic [10:0] i_operando_pm;
    logic [10:0] o_addr_pm;
    logic [10:0] o_addr_dm;
    logic        o_rd_en;
    logic        o_wr_en;
    logic [15:0] o_data;
    logic [15:0] i_data;
    logic        i_dm_ready = 1'b0;
    logic [15:0] o_acc;
    logic        o_halt;
    logic [31:0] o_clk_count;

    always #5 clk = ~clk;

    bip_cpu_mc dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_opcode_pm   (i_opcode_pm),
        .i_operando_pm (i_operando_pm),
        .o_addr_pm     (o_addr_pm),
        .o_addr_dm     (o_addr_dm),
        .o_rd_en       (o_rd_en),
        .o_wr_en       (o_wr_en),
        .o_data        (o_data),
        .i_data        (i_data),
        .i_dm_ready    (i_dm_ready),
        .o_acc         (o_acc),
        .o_halt        (o_halt),
        .o_clk_count   (o_clk_count)
    );

    logic [15:0] pm      [2048];
    logic [15:0] dm_resp [2048];
    logic [15:0] m_mem   [2048];

    assign i_opcode_pm   = pm[o_addr_pm][15:11];
    assign i_operando_pm = pm[o_addr_pm][10:0];
    assign i_data        = dm_resp[o_addr_dm];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Instruction-level model: architectural state changes only when an
    // instruction retires, 2 cycles after it starts plus its wait cycles.
    logic [10:0] m_pc;
    logic [15:0] m_acc;
    bit          m_halt;
    int          m_cnt;
    int          e, dur, lat, req_age;
    int          force_lat = -1;
    bit          model_on = 1'b0;
    logic [4:0]  c_op;
    logic [10:0] c_opnd;
    bit          c_mem;

    function automatic logic [15:0] ins(input logic [4:0] op,
                                        input logic [10:0] a);
        return {op, a};
    endfunction

    task automatic start_instr();
        c_op   = pm[m_pc][15:11];
        c_opnd = pm[m_pc][10:0];
        c_mem  = (c_op == 5'd1 || c_op == 5'd2 || c_op == 5'd4 ||
                  c_op == 5'd6 || c_op == 5'd8);
        lat    = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
        dur    = c_mem ? 2 + lat : 2;
        e      = 0;
    endtask

    task automatic retire();
        logic [15:0] imm;
        logic [15:0] md;
        logic [10:0] nxt;
        imm = {{5{c_opnd[10]}}, c_opnd};
        md  = m_mem[c_opnd];
        nxt = m_pc + 11'd1;
        case (c_op)
            5'd0:  m_halt = 1'b1;
            5'd1:  m_mem[c_opnd] = m_acc;
            5'd2:  m_acc = md;
            5'd3:  m_acc = imm;
            5'd4:  m_acc = m_acc + md;
            5'd5:  m_acc = m_acc + imm;
            5'd6:  m_acc = m_acc - md;
            5'd7:  m_acc = m_acc - imm;
            5'd8:  m_acc = m_acc & md;
            5'd9:  m_acc = m_acc & imm;
            5'd10: nxt = c_opnd;
            5'd11: if (m_acc == 16'd0) nxt = c_opnd;
            5'd12: if (m_acc != 16'd0) nxt = c_opnd;
            default: ;
        endcase
        if (!m_halt) m_pc = nxt;
    endtask

    task automatic model_reset();
        m_pc    = '0;
        m_acc   = '0;
        m_halt  = 1'b0;
        m_cnt   = 0;
        req_age = 0;
        start_instr();
    endtask

    always @(negedge clk) begin
        bit exp_req;
        if (rst || !model_on) begin
            i_dm_ready = 1'b0;
            req_age    = 0;
        end else begin
            if (!m_halt) begin
                m_cnt++;
                e++;
                if (e == dur) begin
                    retire();
                    if (!m_halt) start_instr();
                end
            end
            exp_req = !m_halt && c_mem && e >= 1 && e <= 1 + lat;
            chk("pc", o_addr_pm, m_pc);
            chk("acc", o_acc, m_acc);
            chk("wdata", o_data, m_acc);
            chk("halt", o_halt, m_halt);
            chk("clk_count", o_clk_count, m_cnt);
            chk("rd_en", o_rd_en, exp_req && c_op != 5'd1);
            chk("wr_en", o_wr_en, exp_req && c_op == 5'd1);
            if (exp_req) chk("addr_dm", o_addr_dm, c_opnd);
            // Memory responder; ready pulses with no request are noise.
            if (o_rd_en || o_wr_en) begin
                i_dm_ready = (req_age == lat);
                if (i_dm_ready && o_wr_en) dm_resp[o_addr_dm] = o_data;
                req_age++;
            end else begin
                req_age    = 0;
                i_dm_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic begin_test();
        @(negedge clk);
        #2;
        rst      = 1'b1;
        model_on = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            logic [15:0] v;
            v          = 16'($urandom);
            pm[i]      = 16'd0;
            dm_resp[i] = v;
            m_mem[i]   = v;
        end
    endtask

    task automatic go();
        #1;
        chk("rst_pc", o_addr_pm, 0);
        chk("rst_acc", o_acc, 0);
        chk("rst_halt", o_halt, 0);
        chk("rst_count", o_clk_count, 0);
        chk("rst_rd", o_rd_en, 0);
        chk("rst_wr", o_wr_en, 0);
        model_reset();
        model_on = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int wr_cyc, rd_cyc;
        bit saw2;

        // LDI 5; ADDI -3; HLT with zero wait states
        begin_test();
        force_lat = 0;
        pm[0] = ins(5'd3, 11'd5);
        pm[1] = ins(5'd5, 11'h7FD);
        pm[2] = ins(5'd0, 11'd0);
        go();
        run(12);
        chk("t1_acc", o_acc, 16'd2);
        chk("t1_halt", o_halt, 1);
        chk("t1_pc", o_addr_pm, 11'd2);
        chk("t1_count", o_clk_count, 6);

        // STO/LD with 3 wait cycles per access
        begin_test();
        force_lat = 3;
        pm[0] = ins(5'd3, 11'd7);
        pm[1] = ins(5'd1, 11'h010);
        pm[2] = ins(5'd3, 11'd0);
        pm[3] = ins(5'd2, 11'h010);
        pm[4] = ins(5'd0, 11'd0);
        go();
        wr_cyc = 0;
        rd_cyc = 0;
        repeat (24) begin
            @(negedge clk);
            #1;
            if (o_wr_en && o_addr_dm == 11'h010 && o_data == 16'd7)
                wr_cyc++;
            if (o_rd_en && o_addr_dm == 11'h010) rd_cyc++;
        end
        chk("t2_wr_cycles", wr_cyc, 4);
        chk("t2_rd_cycles", rd_cyc, 4);
        chk("t2_acc", o_acc, 16'd7);
        chk("t2_count", o_clk_count, 16);
        chk("t2_pc", o_addr_pm, 11'd4);

        // BEQ taken over address 2, BNE not taken
        begin_test();
        force_lat = -1;
        pm[0] = ins(5'd3, 11'd0);
        pm[1] = ins(5'd11, 11'd4);
        pm[2] = ins(5'd3, 11'd1);
        pm[3] = ins(5'd0, 11'd0);
        pm[4] = ins(5'd12, 11'd0);
        pm[5] = ins(5'd0, 11'd0);
        go();
        saw2 = 1'b0;
        repeat (16) begin
            @(negedge clk);
            #1;
            if (o_addr_pm == 11'd2) saw2 = 1'b1;
        end
        chk("t3_skip2", saw2, 0);
        chk("t3_pc", o_addr_pm, 11'd5);
        chk("t3_acc", o_acc, 16'd0);
        chk("t3_count", o_clk_count, 8);

        // sign-extended immediates
        begin_test();
        pm[0] = ins(5'd3, 11'h3FF);
        pm[1] = ins(5'd5, 11'h3FF);
        go();
        run(10);
        chk("t4_acc", o_acc, 16'h07FE);
        begin_test();
        pm[0] = ins(5'd3, 11'd0);
        pm[1] = ins(5'd7, 11'd1);
        go();
        run(10);
        chk("t4_wrap", o_acc, 16'hFFFF);

        // NOP at 0x7FF, PC wraps to 0
        begin_test();
        pm[0]      = ins(5'd11, 11'h7FE);
        pm[11'h7FE] = ins(5'd3, 11'd1);
        pm[11'h7FF] = ins(5'h1F, 11'd0);
        pm[1]      = ins(5'd0, 11'd0);
        go();
        run(16);
        chk("t5_pc", o_addr_pm, 11'd1);
        chk("t5_acc", o_acc, 16'd1);
        chk("t5_count", o_clk_count, 10);

        // reset during a stalled read
        begin_test();
        force_lat = 20;
        pm[0] = ins(5'd2, 11'd5);
        go();
        run(3);
        chk("t6_rd_stall", o_rd_en, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rd_abort", o_rd_en, 0);
        chk("t6_pc", o_addr_pm, 0);
        chk("t6_count", o_clk_count, 0);
        model_on  = 1'b0;
        force_lat = -1;
        dm_resp[5] = 16'h1234;
        m_mem[5]   = 16'h1234;
        pm[1] = ins(5'd0, 11'd0);
        go();
        run(1);
        chk("t6_restart", o_clk_count, 1);
        run(12);
        chk("t6_acc", o_acc, 16'h1234);
        chk("t6_halt", o_halt, 1);

        // random programs
        for (int t = 0; t < 20; t++) begin
            begin_test();
            for (int a = 0; a < 64; a++) begin
                logic [4:0]  op;
                logic [10:0] opnd;
                op = 5'($urandom_range(0, 15));
                if (op == 5'd0 && $urandom_range(0, 3) != 0) op = 5'd3;
                if (op == 5'd1 || op == 5'd2 || op == 5'd4 ||
                    op == 5'd6 || op == 5'd8)
                    opnd = 11'($urandom_range(0, 15));
                else if (op >= 5'd10 && op <= 5'd12)
                    opnd = 11'($urandom_range(0, 63));
                else
                    opnd = 11'($urandom);
                pm[a] = ins(op, opnd);
            end
            go();
            run(300);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bip_cpu_mc.md
Name: bip_cpu_mc

Overview:
- Multi-cycle BIP accumulator core: merges control FSM and accumulator datapath into one parametrised block.
- Adds conditional/unconditional branches, logical ops, sign-extended immediates, a data-memory wait-state handshake, a halt state and a cycle counter.
- Sits between program memory (combinational read) and data RAM.
- Feeds o_acc, o_halt and o_clk_count to the debug/UART top.

Parameters:
- NB_OPCODE, 5, opcode field width.
- NB_OPERANDO, 11, operand field width; also the data-memory address width.
- NB_ADDR, 11, program counter / program memory address width.
- NB_DATA, 16, accumulator and data-memory word width; must be >= NB_OPERANDO.
- NB_CNT, 32, cycle counter width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_opcode_pm  in  NB_OPCODE  opcode at o_addr_pm (combinational program memory).
- i_operando_pm  in  NB_OPERANDO  operand at o_addr_pm.
- o_addr_pm  out  NB_ADDR  program counter.
- o_addr_dm  out  NB_OPERANDO  data-memory address.
- o_rd_en  out  1  data-memory read request.
- o_wr_en  out  1  data-memory write request.
- o_data  out  NB_DATA  write data (always equals ACC).
- i_data  in  NB_DATA  read data, valid when i_dm_ready=1.
- i_dm_ready  in  1  data-memory completion for the current request.
- o_acc  out  NB_DATA  accumulator.
- o_halt  out  1  core halted.
- o_clk_count  out  NB_CNT  cycles elapsed since reset, frozen at halt.

Behaviour:
- Reset (async, i_rst=1) clears PC, ACC, IR, o_clk_count, o_halt, o_rd_en and o_wr_en to 0 and sets state to FETCH. All outputs read 0 while in reset.
- Opcodes:
  - 00000 HLT; 00001 STO; 00010 LD; 00011 LDI; 00100 ADD; 00101 ADDI; 00110 SUB; 00111 SUBI.
  - 01000 AND; 01001 ANDI; 01010 JMP; 01011 BEQ; 01100 BNE.
  - Any other opcode is a NOP: PC+1 with no other effect.
- Immediates are the operand sign-extended to NB_DATA.
- Memory ops (STO, LD, ADD, SUB, AND) use the operand as the data address.
- Branch target is the operand zero-extended/truncated to NB_ADDR, absolute.
- Arithmetic is modulo 2^NB_DATA. No flags are kept; BEQ/BNE test ACC==0 at EXEC.
- FSM has four states, 2 bits, encoding FETCH=0, EXEC=1, MEM=2, HALT=3.
  - FETCH: latch {i_opcode_pm, i_operando_pm} into IR; go to EXEC.
  - EXEC, non-memory op:
    - Update ACC/PC in this cycle.
    - PC <= target for JMP, for BEQ with ACC==0, and for BNE with ACC!=0; otherwise PC <= PC+1.
    - Go to FETCH. HLT instead goes to HALT with PC unchanged.
  - EXEC, memory op:
    - Drive o_addr_dm = operand; o_rd_en=1 (or o_wr_en=1 for STO) combinationally.
    - If i_dm_ready=1 in the same cycle: complete (ACC updated from i_data for reads), PC+1, go to FETCH.
    - Otherwise go to MEM.
  - MEM: hold o_addr_dm, o_rd_en/o_wr_en and o_data stable. On i_dm_ready=1: complete as above, PC+1, go to FETCH. Otherwise stay in MEM; there is no timeout.
  - HALT: o_halt=1, o_rd_en/o_wr_en=0, PC/ACC frozen. Only reset exits.
- o_rd_en/o_wr_en are never both 1. Both are 0 in FETCH and HALT.
- CPI: non-memory instructions take 2 cycles; memory instructions take 2 + wait cycles.
- PC wraps from 2^NB_ADDR-1 to 0.
- o_clk_count increments every cycle outside reset and outside HALT. It includes the HLT EXEC cycle and saturates at all-ones.
- Reset asserted mid-MEM aborts the access immediately; requests drop asynchronously.
- i_dm_ready high while no request is outstanding is ignored.

Decomposition:
- Shared package bip_pkg holds:
  - Opcode constants (OP_HLT ... OP_BNE).
  - FSM state encodings.
  - Default widths.
- One natural sub-module, bip_alu: combinational. Inputs are ACC, operand (memory data or immediate) and op. Outputs are the next ACC value and the zero test. The FSM, PC, IR and counter remain in bip_cpu_mc.

Test Plan:
- Reset, then LDI 5; ADDI -3 (0x7FD); HLT, with i_dm_ready tied 1 -> o_acc=2, o_halt=1, o_addr_pm=2, o_clk_count=6, frozen thereafter.
- LDI 7; STO 0x010; LDI 0; LD 0x010; HLT, with i_dm_ready delayed 3 cycles per access:
  - o_wr_en held 4 cycles with o_addr_dm=0x010 and o_data=7.
  - Final o_acc=7; requests stable throughout the wait.
- LDI 0; BEQ 4; LDI 1; HLT; (addr 4) BNE 0; HLT -> PC skips address 2; BNE not taken; halts at address 5 with o_acc=0.
- LDI 0x3FF; ADDI 0x3FF with NB_DATA=16 -> o_acc=0x07FE (immediates sign-extend to 0x03FF); SUBI 1 from ACC=0 -> 0xFFFF (wrap).
- Program at 0x7FF holds NOP (opcode 11111) -> PC wraps to 0x000 and execution continues.
- Assert i_rst during MEM with o_rd_en=1 -> o_rd_en=0 immediately; after release PC=0, ACC=0, o_clk_count restarts at 0.
